// File: rtl/mux_arbiter_2_1.sv
// mux_arbiter_2_1: two-requester arbiter driving a shared 2:1 multiplexer.
// Ties go to the requester that did not win last. A hold counter limits how
// long one requester keeps the line while the other waits. Every release
// passes through IDLE, so the two grants never overlap.
`timescale 1ns/1ps
module mux_arbiter_2_1 #(
  parameter int MAX_HOLD = 8
) (
  input  logic Clock_In,
  input  logic Reset_In,
  input  logic Req_0_In,
  input  logic Req_1_In,
  input  logic Data_0_In,
  input  logic Data_1_In,
  output logic Grant_0_Out,
  output logic Grant_1_Out,
  output logic Select_Out,
  output logic Enable_Out,
  output logic MUX_Data_Out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_0 = 2'd1,
    ST_GRANT_1 = 2'd2
  } state_e;

  // Last counter value before the owner must yield to a waiting requester.
  localparam logic [7:0] HOLD_LAST_C = 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       select_q, select_d;
  logic       grant_0_q, grant_0_d;
  logic       grant_1_q, grant_1_d;
  logic       enable_q, enable_d;

  // State and output registers; reset clears the grants asynchronously.
  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      hold_cnt_q   <= 8'd0;
      select_q     <= 1'b0;
      grant_0_q    <= 1'b0;
      grant_1_q    <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      select_q     <= select_d;
      grant_0_q    <= grant_0_d;
      grant_1_q    <= grant_1_d;
      enable_q     <= enable_d;
    end
  end

  // Next-state logic: arbitrate from IDLE, release on drop or on forced yield.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Req_0_In && Req_1_In) begin
          // Tie: the requester that did not win last time gets the line.
          if (last_grant_q) begin
            state_d = ST_GRANT_0;
          end else begin
            state_d = ST_GRANT_1;
          end
        end else if (Req_0_In) begin
          state_d = ST_GRANT_0;
        end else if (Req_1_In) begin
          state_d = ST_GRANT_1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT_0: begin
        if (!Req_0_In) begin
          state_d = ST_IDLE;
        end else if ((hold_cnt_q == HOLD_LAST_C) && Req_1_In) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT_0;
        end
      end
      ST_GRANT_1: begin
        if (!Req_1_In) begin
          state_d = ST_IDLE;
        end else if ((hold_cnt_q == HOLD_LAST_C) && Req_0_In) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT_1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output/datapath next values derived from the transition being taken.
  always_comb begin
    last_grant_d = last_grant_q;
    select_d     = select_q;
    hold_cnt_d   = 8'd0;
    grant_0_d    = (state_d == ST_GRANT_0);
    grant_1_d    = (state_d == ST_GRANT_1);
    enable_d     = (state_d == ST_GRANT_0) || (state_d == ST_GRANT_1);

    if ((state_q == ST_IDLE) && (state_d == ST_GRANT_0)) begin
      last_grant_d = 1'b0;
      select_d     = 1'b0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_GRANT_1)) begin
      last_grant_d = 1'b1;
      select_d     = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
      select_d     = select_q;
    end

    // Count only while the same grant is kept; entry and IDLE restart at zero.
    if ((state_q != ST_IDLE) && (state_d == state_q)) begin
      if (hold_cnt_q == HOLD_LAST_C) begin
        hold_cnt_d = hold_cnt_q;
      end else begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end
    end else begin
      hold_cnt_d = 8'd0;
    end
  end

  // Shared multiplexer: forced to 0 whenever no grant is held.
  always_comb begin
    if (enable_q) begin
      if (select_q) begin
        MUX_Data_Out = Data_1_In;
      end else begin
        MUX_Data_Out = Data_0_In;
      end
    end else begin
      MUX_Data_Out = 1'b0;
    end
  end

  assign Grant_0_Out = grant_0_q;
  assign Grant_1_Out = grant_1_q;
  assign Select_Out  = select_q;
  assign Enable_Out  = enable_q;

endmodule

// File: tb/tb_mux_arbiter_2_1.sv
// Scoreboard bench for mux_arbiter_2_1 with MAX_HOLD = 4.
// Expected vector order: {Grant_0, Grant_1, Select, Enable, MUX_Data}.
`timescale 1ns/1ps
module tb_mux_arbiter_2_1;

  logic Clock_In;
  logic Reset_In;
  logic Req_0_In;
  logic Req_1_In;
  logic Data_0_In;
  logic Data_1_In;
  logic Grant_0_Out;
  logic Grant_1_Out;
  logic Select_Out;
  logic Enable_Out;
  logic MUX_Data_Out;

  typedef struct {
    string      name;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  mux_arbiter_2_1 #(.MAX_HOLD(4)) dut (
    .Clock_In     (Clock_In),
    .Reset_In     (Reset_In),
    .Req_0_In     (Req_0_In),
    .Req_1_In     (Req_1_In),
    .Data_0_In    (Data_0_In),
    .Data_1_In    (Data_1_In),
    .Grant_0_Out  (Grant_0_Out),
    .Grant_1_Out  (Grant_1_Out),
    .Select_Out   (Select_Out),
    .Enable_Out   (Enable_Out),
    .MUX_Data_Out (MUX_Data_Out)
  );

  initial begin
    Clock_In = 1'b0;
    forever #5 Clock_In = ~Clock_In;
  end

  // Monitor: after each clock edge (or an explicit between-edge check) pop and compare.
  initial begin
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(posedge Clock_In or chk_ev);
      #2;
      if (q.size() != 0) begin
        e   = q.pop_front();
        act = {Grant_0_Out, Grant_1_Out, Select_Out, Enable_Out, MUX_Data_Out};
        total_cnt++;
        if (act === e.v) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: got g0g1 sel en mux=%b expected %b", e.name, act, e.v);
        end
      end
    end
  end

  // Drive inputs at the falling edge; expected outputs hold after the next rising edge.
  task automatic step(input string name, input logic r0, input logic r1,
                      input logic d0, input logic d1, input logic [4:0] exp_v);
    exp_t e;
    Req_0_In  = r0;
    Req_1_In  = r1;
    Data_0_In = d0;
    Data_1_In = d1;
    @(posedge Clock_In);
    e.name = name;
    e.v    = exp_v;
    q.push_back(e);
    @(negedge Clock_In);
  endtask

  // Check outputs between clock edges (used while reset is asserted).
  task automatic check_now(input string name, input logic [4:0] exp_v);
    exp_t e;
    #1;
    e.name = name;
    e.v    = exp_v;
    q.push_back(e);
    -> chk_ev;
    #3;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    Reset_In  = 1'b0;
    Req_0_In  = 1'b0;
    Req_1_In  = 1'b0;
    Data_0_In = 1'b1;
    Data_1_In = 1'b1;
    #10;
    check_now("reset_state", 5'b00000);
    @(negedge Clock_In);
    Reset_In = 1'b1;

    // Tie after reset goes to requester 0, then forced rotation every 4 cycles.
    step("tie_first_g0", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10011);
    for (int i = 0; i < 3; i++) step("rot_g0_hold", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10011);
    step("rot_idle_a", 1'b1, 1'b1, 1'b1, 1'b0, 5'b00000);
    for (int i = 0; i < 4; i++) step("rot_g1_hold", 1'b1, 1'b1, 1'b1, 1'b0, 5'b01110);
    step("rot_idle_b_sel_kept", 1'b1, 1'b1, 1'b1, 1'b0, 5'b00100);
    step("rot_back_g0", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10011);
    step("release_g0", 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000);

    // Lone requester keeps the line past the hold limit.
    for (int i = 0; i < 10; i++) step("sat_g1", 1'b0, 1'b1, 1'b0, 1'b1, 5'b01111);
    step("sat_release", 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100);

    // Data follows requester 1 while granted, zero in IDLE.
    step("mux_d1_0", 1'b0, 1'b1, 1'b1, 1'b0, 5'b01110);
    step("mux_d1_1", 1'b0, 1'b1, 1'b1, 1'b1, 5'b01111);
    step("mux_d1_0b", 1'b0, 1'b1, 1'b1, 1'b0, 5'b01110);
    step("mux_idle_zero", 1'b0, 1'b0, 1'b1, 1'b1, 5'b00100);

    // Release and other request at the same edge: IDLE first, then grant.
    step("g0_enter", 1'b1, 1'b0, 1'b0, 1'b1, 5'b10010);
    step("swap_idle", 1'b0, 1'b1, 1'b0, 1'b1, 5'b00000);
    step("swap_g1", 1'b0, 1'b1, 1'b0, 1'b1, 5'b01111);
    step("swap_release", 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100);

    // Reset mid-GRANT_0 (Last_Grant = 0) must restore the tie preference.
    step("pre_rst_g0", 1'b1, 1'b0, 1'b1, 1'b0, 5'b10011);
    Req_0_In = 1'b0;
    Req_1_In = 1'b0;
    Reset_In = 1'b0;
    check_now("rst_mid_g0", 5'b00000);
    Reset_In = 1'b1;
    @(negedge Clock_In);
    step("tie_after_rst_a", 1'b1, 1'b1, 1'b1, 1'b0, 5'b10011);
    step("g0_drop", 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000);

    // Reset mid-GRANT_1 drops the grant and data immediately.
    step("pre_rst_g1", 1'b0, 1'b1, 1'b0, 1'b1, 5'b01111);
    Req_0_In = 1'b0;
    Req_1_In = 1'b0;
    Reset_In = 1'b0;
    check_now("rst_mid_g1", 5'b00000);
    Reset_In = 1'b1;
    @(negedge Clock_In);
    step("tie_after_rst_b", 1'b1, 1'b1, 1'b0, 1'b1, 5'b10010);
    step("final_idle", 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000);

    for (int i = 0; (i < 10) && (q.size() != 0); i++) @(negedge Clock_In);
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_2_1.md
MUX_ARBITER_2_1 -- requirements
Module: mux_arbiter_2_1

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, giving the maximum grant cycles while the other requester waits; legal range 2..255.
REQ-002 SHALL have port Clock_In, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_In, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port Req_0_In, input, 1, requester 0 requests the shared line.
REQ-005 SHALL have port Req_1_In, input, 1, requester 1 requests the shared line.
REQ-006 SHALL have port Data_0_In, input, 1, requester 0 data.
REQ-007 SHALL have port Data_1_In, input, 1, requester 1 data.
REQ-008 SHALL have port Grant_0_Out, output, 1, requester 0 owns the line.
REQ-009 SHALL have port Grant_1_Out, output, 1, requester 1 owns the line.
REQ-010 SHALL have port Select_Out, output, 1, select line for the shared 2:1 MUX; 0 = Data_0_In.
REQ-011 SHALL have port Enable_Out, output, 1, enable for the shared 2:1 MUX; high only while a grant is held.
REQ-012 SHALL have port MUX_Data_Out, output, 1, multiplexed data; driven 0 (never Z) when Enable_Out is low.

Function
REQ-013 SHALL implement three states: IDLE, GRANT_0, GRANT_1; Grant_0_Out = (state == GRANT_0), Grant_1_Out = (state == GRANT_1), Enable_Out = Grant_0_Out | Grant_1_Out; all registered.
REQ-014 SHALL hold a Last_Grant bit; arbitration ties go to the requester not equal to Last_Grant.
REQ-015 IDLE: Req_0 only -> GRANT_0; Req_1 only -> GRANT_1; both -> per REQ-014; neither -> stay IDLE.
REQ-016 Grant latency: request sampled high at edge k, with state IDLE, -> grant high after edge k.
REQ-017 On entry to GRANT_x, SHALL set Last_Grant = x, clear the hold counter, and set Select_Out = x.
REQ-018 In GRANT_x, the hold counter SHALL increment each cycle and saturate at MAX_HOLD-1 (8-bit counter).
REQ-019 GRANT_x with Req_x low at an edge -> IDLE (voluntary release), regardless of the counter.
REQ-020 GRANT_x with Req_x high, counter == MAX_HOLD-1 and other request high -> IDLE (forced release).
REQ-021 GRANT_x with counter saturated and the other request low -> stay GRANT_x indefinitely.
REQ-022 Every exit from GRANT_x SHALL pass through at least one IDLE cycle (break-before-make); no direct GRANT_0<->GRANT_1 transition.
REQ-023 Select_Out SHALL hold its last value in IDLE and change only on entry to a GRANT state.
REQ-024 MUX_Data_Out SHALL be combinational: Enable_Out ? (Select_Out ? Data_1_In : Data_0_In) : 0.
REQ-025 Simultaneous release and other request in the same cycle: release wins -> IDLE; the other requester is granted on the next edge.
REQ-026 Max wait for a continuously requesting requester SHALL be MAX_HOLD + 2 cycles.

Reset
REQ-027 On Reset_In low, asynchronously: state = IDLE, Last_Grant = 1, counter = 0, Select_Out = 0, all grants and Enable_Out = 0, MUX_Data_Out = 0.
REQ-028 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-029 After deassertion, the first arbitration on a tie SHALL grant requester 0.

Verification (MAX_HOLD = 4)
REQ-030 Reset, then Req_0 = Req_1 = 1 at the same edge -> Grant_0 next cycle, Select_Out = 0, Enable_Out = 1.
REQ-031 Both held high -> Grant_0 for 4 cycles, 1 IDLE cycle, then Grant_1 for 4 cycles, 1 IDLE cycle, then Grant_0; Enable_Out low during each IDLE cycle.
REQ-032 Req_1 alone held for 10 cycles -> Grant_1 stays high for all 10 cycles (saturation); Req_1 drops -> IDLE next edge.
REQ-033 In GRANT_1, Data_1_In toggles 0,1,0 and Data_0_In = 1 -> MUX_Data_Out follows 0,1,0; in IDLE -> MUX_Data_Out = 0.
REQ-034 Reset_In pulsed low mid-GRANT_1 between clock edges -> Grant_1_Out, Enable_Out and MUX_Data_Out = 0 immediately; a tie after release grants requester 0.
REQ-035 In GRANT_0, Req_0 drops and Req_1 rises at the same edge -> IDLE for one cycle, then GRANT_1 with Select_Out = 1.
